// File: rtl/ifu_pkg.sv
// Shared constants for the instruction-fetch unit: FSM state encodings and AXI response codes.
package ifu_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t F_IDLE = 3'd0;
    localparam fetch_state_t F_AR   = 3'd1;
    localparam fetch_state_t F_R    = 3'd2;
    localparam fetch_state_t F_DONE = 3'd3;
    localparam fetch_state_t F_WAIT = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/Reg.sv
// Generic register cell: synchronous active-high reset to RESET_VAL, load on wen.
module Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    output logic [WIDTH-1:0] dout
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)      dout <= RESET_VAL;
        else if (wen) dout <= din;
    end

endmodule

// File: rtl/ifu_lane_sel.sv
// Picks the 32-bit instruction out of a 64-bit read beat using PC bit 2.
module ifu_lane_sel (
    input  logic [63:0] rdata,
    input  logic        pc2,
    output logic [31:0] inst_word
);

    assign inst_word = pc2 ? rdata[63:32] : rdata[31:0];

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding AXI-lite instruction fetch: IDLE -> AR -> R -> DONE -> WAIT -> AR ...
// Build option IFU_MISALIGN_CHECK_EN: misaligned PCs skip the bus and report fetch_err.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_finish,
    input  logic [ADDR_WIDTH-1:0] dnpc,
    output logic [31:0]           araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [63:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           inst,
    output logic                  inst_update,
    output logic                  fetch_err
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           inst_q;
    logic                  inst_update_q;
    logic                  fetch_err_q;
    logic                  misaligned;
    logic [31:0]           inst_word;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    Reg #(
        .WIDTH     (3),
        .RESET_VAL (F_IDLE)
    ) u_state_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (state_d),
        .wen  (1'b1),
        .dout (state_q)
    );

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE: state_d = F_AR;
            F_AR:   if (misaligned) state_d = F_DONE;
                    else if (arready) state_d = F_R;
            F_R:    if (rvalid) state_d = F_DONE;
            F_DONE: state_d = F_WAIT;
            F_WAIT: if (inst_finish) state_d = F_AR;
            default: state_d = F_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (state_q == F_AR) && !misaligned;
        rready  = (state_q == F_R);
    end

    ifu_lane_sel u_lane_sel (
        .rdata     (rdata),
        .pc2       (pc_q[2]),
        .inst_word (inst_word)
    );

    // inst_update is registered off F_DONE, so the pulse lands the cycle after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC[ADDR_WIDTH-1:0];
            inst_q        <= '0;
            inst_update_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            inst_update_q <= (state_q == F_DONE);
            if (state_q == F_WAIT && inst_finish) pc_q <= dnpc;
            if (state_q == F_R && rvalid) begin
                inst_q      <= inst_word;
                fetch_err_q <= (rresp != AXI_RESP_OKAY);
            end else if (state_q == F_AR && misaligned) begin
                inst_q      <= '0;
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign araddr      = pc_q[31:0];
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign inst_update = inst_update_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, PC value loaded at reset.
REQ-002 Parameter ADDR_WIDTH, default 64, PC/dnpc width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inst_finish  input  1  one-cycle pulse from the downstream pipeline: the current instruction has retired.
REQ-006 dnpc  input  ADDR_WIDTH  next PC, sampled when inst_finish=1.
REQ-007 araddr  output  32  AXI-lite read address, equal to pc[31:0].
REQ-008 arvalid  output  1  AXI-lite read address valid.
REQ-009 arready  input  1  AXI-lite read address ready.
REQ-010 rdata  input  64  AXI-lite read data.
REQ-011 rresp  input  2  AXI-lite read response.
REQ-012 rvalid  input  1  AXI-lite read data valid.
REQ-013 rready  output  1  AXI-lite read data ready.
REQ-014 pc  output  ADDR_WIDTH  PC of the instruction being fetched or held.
REQ-015 inst  output  32  fetched instruction, registered.
REQ-016 inst_update  output  1  one-cycle pulse: inst/pc are valid for a new instruction.
REQ-017 fetch_err  output  1  registered error flag for the current instruction, valid while inst_update=1 and held until the next fetch.

Function
REQ-018 The FSM SHALL have states F_IDLE, F_AR, F_R, F_DONE and F_WAIT.
REQ-019 F_IDLE SHALL go to F_AR on the next clock, once per reset.
REQ-020 F_AR SHALL drive arvalid=1 and hold araddr stable, going to F_R on the cycle where arvalid&arready=1.
REQ-021 F_R SHALL drive rready=1; on rvalid=1 it SHALL capture the instruction and go to F_DONE.
REQ-022 The captured inst SHALL be rdata[63:32] when pc[2]=1 and rdata[31:0] when pc[2]=0.
REQ-023 In F_R, fetch_err SHALL capture (rresp!=2'b00) when rvalid=1.
REQ-024 F_DONE SHALL assert inst_update=1 for exactly one cycle, then go to F_WAIT.
REQ-025 F_WAIT SHALL hold pc and inst; on inst_finish=1 it SHALL load pc<=dnpc and go to F_AR.
REQ-026 inst_finish received in any state other than F_WAIT SHALL be ignored, with pc unchanged.
REQ-027 arvalid SHALL be 0 outside F_AR, and rready SHALL be 0 outside F_R.
REQ-028 Once asserted, arvalid SHALL not drop until arready=1, whatever the inst_finish input does.
REQ-029 Minimum latency from entering F_AR to inst_update SHALL be 3 cycles, given arready=1 and rvalid=1 on the first possible cycles.

Reset
REQ-030 In reset the block SHALL force state=F_IDLE, pc=RESET_PC, inst=32'h0, inst_update=0, fetch_err=0, arvalid=0 and rready=0.
REQ-031 Reset asserted mid-transaction, in F_AR or F_R, SHALL abandon the transaction at once with no inst_update pulse; the first fetch after reset SHALL be at RESET_PC.

Configuration
REQ-032 With IFU_MISALIGN_CHECK_EN defined, pc[1:0]!=0 on entry to F_AR SHALL skip the bus transaction (arvalid stays 0), set fetch_err=1 and inst=32'h0, and go directly to F_DONE.
REQ-033 With IFU_MISALIGN_CHECK_EN undefined, no alignment check SHALL exist, and misaligned PCs SHALL be fetched normally per REQ-022.

Structure
REQ-034 Constants F_IDLE..F_WAIT (3-bit) and AXI_RESP_OKAY=2'b00 SHALL live in a shared package ifu_pkg.
REQ-035 The 64-to-32 lane select SHALL be a sub-module ifu_lane_sel (inputs rdata and pc[2], output inst_word).
REQ-036 The state register SHALL be instantiated through the codebase's generic Reg cell.

Verification
REQ-037 Reset release, arready and rvalid tied to 1, rdata=64'h0000_0013_0000_0093 -> araddr=32'h8000_0000, inst=32'h0000_0093 and inst_update pulse 4 cycles after rst deasserts.
REQ-038 inst_finish with dnpc=64'h8000_0004 and the same rdata -> araddr=32'h8000_0004 and inst=32'h0000_0013.
REQ-039 arready held 0 for 5 cycles -> arvalid stays 1 and araddr stays stable, with no inst_update.
REQ-040 rvalid with rresp=2'b10 -> fetch_err=1 during the inst_update pulse; the next clean fetch returns fetch_err=0.
REQ-041 rst asserted while in F_R -> no inst_update, and the refetch is at 32'h8000_0000.
REQ-042 With IFU_MISALIGN_CHECK_EN defined, dnpc=64'h8000_0002 -> no arvalid, fetch_err=1 and inst=0 with an inst_update pulse.
